mpc_mac_pipe: RTL and testbench

//  Parametrised pipelined multiply-accumulate unit: the next generation of the fixed-size mpc_mul_mul_* DSP multipliers.

---
 rtl/mpc_mac_pkg.sv | 33 +++
 rtl/mpc_mac_mul_pipe.sv | 57 +++++
 rtl/mpc_mac_pipe.sv | 107 ++++++++++
 tb/tb_mpc_mac_pipe.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mpc_mac_pkg.sv
// Shared helpers for the MAC pipeline: product width and wide signed
// round/clamp arithmetic evaluated on a common wide type.
package mpc_mac_pkg;

  localparam int MAX_W = 128;

  typedef logic signed [MAX_W-1:0] wide_t;

  function automatic int prod_w(input int a_w, input int b_w);
    return a_w + b_w + 2;
  endfunction

  function automatic wide_t max_of(input int width);
    return (wide_t'(1) <<< (width - 1)) - wide_t'(1);
  endfunction

  function automatic wide_t min_of(input int width);
    return -(wide_t'(1) <<< (width - 1));
  endfunction

  function automatic wide_t sat_clamp(input wide_t value, input int width);
    if (value > max_of(width)) return max_of(width);
    if (value < min_of(width)) return min_of(width);
    return value;
  endfunction

  // Round half toward +inf, then arithmetic shift.
  function automatic wide_t round_shift(input wide_t value, input int shift);
    if (shift == 0) return value;
    return (value + (wide_t'(1) <<< (shift - 1))) >>> shift;
  endfunction

endpackage

// File: rtl/mpc_mac_mul_pipe.sv
// Extended-operand multiply followed by MUL_STAGES clock-enabled registers,
// with the valid/first/last tags shifted alongside the product.
module mpc_mac_mul_pipe #(
  parameter int A_W        = 21,
  parameter int B_W        = 14,
  parameter int A_SIGNED   = 1,
  parameter int B_SIGNED   = 0,
  parameter int MUL_STAGES = 3
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       ce,
  input  logic                       in_valid,
  input  logic                       in_first,
  input  logic                       in_last,
  input  logic [A_W-1:0]             a,
  input  logic [B_W-1:0]             b,
  output logic                       p_valid,
  output logic                       p_first,
  output logic                       p_last,
  output logic signed [A_W+B_W+1:0]  p_data
);

  localparam int PW = A_W + B_W + 2;

  logic signed [A_W:0]    a_ext;
  logic signed [B_W:0]    b_ext;
  logic signed [PW-1:0]   prod;
  logic signed [PW-1:0]   prod_q [MUL_STAGES];
  logic [2:0]             tag_q  [MUL_STAGES];

  assign a_ext = {(A_SIGNED != 0) & a[A_W-1], a};
  assign b_ext = {(B_SIGNED != 0) & b[B_W-1], b};
  assign prod  = PW'(a_ext) * PW'(b_ext);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MUL_STAGES; i++) begin
        prod_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else if (ce) begin
      prod_q[0] <= prod;
      tag_q[0]  <= {in_valid, in_first, in_last};
      for (int i = 1; i < MUL_STAGES; i++) begin
        prod_q[i] <= prod_q[i-1];
        tag_q[i]  <= tag_q[i-1];
      end
    end
  end

  assign p_data  = prod_q[MUL_STAGES-1];
  assign p_valid = tag_q[MUL_STAGES-1][2];
  assign p_first = tag_q[MUL_STAGES-1][1];
  assign p_last  = tag_q[MUL_STAGES-1][0];

endmodule

// File: rtl/mpc_mac_pipe.sv
// Pipelined multiply-accumulate: product pipe, saturating accumulator with
// sticky overflow, and a rounding/saturating result register per sequence.
module mpc_mac_pipe
  import mpc_mac_pkg::*;
#(
  parameter int A_W        = 21,
  parameter int B_W        = 14,
  parameter int A_SIGNED   = 1,
  parameter int B_SIGNED   = 0,
  parameter int MUL_STAGES = 3,
  parameter int ACC_W      = 48,
  parameter int OUT_W      = 35,
  parameter int SHIFT      = 0,
  parameter int SAT        = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ce,
  input  logic             in_valid,
  input  logic             in_first,
  input  logic             in_last,
  input  logic [A_W-1:0]   a,
  input  logic [B_W-1:0]   b,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sat
);

  localparam int PW = prod_w(A_W, B_W);

  logic                 p_valid, p_first, p_last;
  logic signed [PW-1:0] p_data;

  mpc_mac_mul_pipe #(
    .A_W        (A_W),
    .B_W        (B_W),
    .A_SIGNED   (A_SIGNED),
    .B_SIGNED   (B_SIGNED),
    .MUL_STAGES (MUL_STAGES)
  ) u_mul (
    .clk      (clk),
    .reset_n  (reset_n),
    .ce       (ce),
    .in_valid (in_valid),
    .in_first (in_first),
    .in_last  (in_last),
    .a        (a),
    .b        (b),
    .p_valid  (p_valid),
    .p_first  (p_first),
    .p_last   (p_last),
    .p_data   (p_data)
  );

  logic signed [ACC_W-1:0] acc;
  logic                    ovf, acc_valid, acc_last;
  wide_t                   prod_wide, acc_wide, sum_wide, acc_next;
  logic                    acc_hit;

  assign prod_wide = wide_t'(p_data);
  assign acc_wide  = wide_t'(acc);
  assign sum_wide  = p_first ? prod_wide : acc_wide + prod_wide;
  assign acc_next  = sat_clamp(sum_wide, ACC_W);
  assign acc_hit   = (acc_next != sum_wide);

  // Overflow stays set for the rest of the sequence; only a first term clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc       <= '0;
      ovf       <= 1'b0;
      acc_valid <= 1'b0;
      acc_last  <= 1'b0;
    end else if (ce) begin
      acc_valid <= p_valid;
      acc_last  <= p_last;
      if (p_valid) begin
        acc <= acc_next[ACC_W-1:0];
        ovf <= (ovf & ~p_first) | acc_hit;
      end
    end
  end

  wide_t            r_wide, r_sat;
  logic             clamp_hit, emit;
  logic [OUT_W-1:0] r_out;

  assign r_wide    = round_shift(acc_wide, SHIFT);
  assign r_sat     = sat_clamp(r_wide, OUT_W);
  assign clamp_hit = (SAT != 0) && (r_sat != r_wide);
  assign r_out     = (SAT != 0) ? r_sat[OUT_W-1:0] : r_wide[OUT_W-1:0];
  assign emit      = acc_valid & acc_last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (ce) begin
      out_valid <= emit;
      if (emit) begin
        out_data <= r_out;
        out_sat  <= ovf | clamp_hit;
      end
    end
  end

endmodule

// File: tb/tb_mpc_mac_pipe.sv
// Bench for mpc_mac_pipe: three parameterisations share one stimulus stream and
// are compared every cycle against a sequence-level arithmetic model.
module tb_mpc_mac_pipe;

  localparam int A_W   = 21;
  localparam int B_W   = 14;
  localparam int ACC_W = 48;
  localparam int LAT   = 4;  // enabled edges from accepting edge to result edge

  logic clk = 1'b0;
  logic reset_n = 1'b0, ce = 1'b0;
  logic in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0;
  logic [A_W-1:0] a = '0;
  logic [B_W-1:0] b = '0;

  logic        ov0, ov1, ov2, os0, os1, os2;
  logic [34:0] od0;
  logic [15:0] od1;
  logic [34:0] od2;

  always #5 clk = ~clk;

  mpc_mac_pipe u0 (
    .clk(clk), .reset_n(reset_n), .ce(ce), .in_valid(in_valid), .in_first(in_first),
    .in_last(in_last), .a(a), .b(b), .out_valid(ov0), .out_data(od0), .out_sat(os0));

  mpc_mac_pipe #(.OUT_W(16)) u1 (
    .clk(clk), .reset_n(reset_n), .ce(ce), .in_valid(in_valid), .in_first(in_first),
    .in_last(in_last), .a(a), .b(b), .out_valid(ov1), .out_data(od1), .out_sat(os1));

  mpc_mac_pipe #(.SHIFT(4)) u2 (
    .clk(clk), .reset_n(reset_n), .ce(ce), .in_valid(in_valid), .in_first(in_first),
    .in_last(in_last), .a(a), .b(b), .out_valid(ov2), .out_data(od2), .out_sat(os2));

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  int ow [3] = '{35, 16, 35};
  int sh [3] = '{0, 0, 4};

  function automatic longint clampw(input longint v, input int w, output bit hit);
    longint mx, mn;
    mx  = (longint'(1) <<< (w - 1)) - 1;
    mn  = -mx - 1;
    hit = 1'b0;
    if (v > mx) begin hit = 1'b1; return mx; end
    if (v < mn) begin hit = 1'b1; return mn; end
    return v;
  endfunction

  typedef struct {
    longint d0, d1, d2;
    bit     s0, s1, s2;
    int     due;
  } res_t;

  res_t   q[$];
  longint m_acc = 0;
  bit     m_ovf = 1'b0;
  int     en_cnt = 0;
  bit     e_v = 1'b0;
  longint e_d [3] = '{0, 0, 0};
  bit     e_s [3] = '{0, 0, 0};

  function automatic void predict(input longint acc, input bit ovf, input int k,
                                  output longint d, output bit s);
    longint r;
    bit hit;
    r = acc;
    if (sh[k] > 0) r = (acc + (longint'(1) <<< (sh[k] - 1))) >>> sh[k];
    d = clampw(r, ow[k], hit);
    s = ovf | hit;
  endfunction

  always @(posedge clk) begin
    longint av, bv, sum;
    bit hit;
    res_t rr;
    if (!reset_n) begin
      m_acc = 0;
      m_ovf = 1'b0;
      q.delete();
      e_v = 1'b0;
      e_d = '{0, 0, 0};
      e_s = '{0, 0, 0};
    end else if (ce) begin
      en_cnt++;
      if (in_valid) begin
        av = longint'($signed(a));
        bv = longint'(b);
        if (in_first) begin
          m_acc = av * bv;
          m_ovf = 1'b0;
        end else begin
          sum   = m_acc + av * bv;
          m_acc = clampw(sum, ACC_W, hit);
          m_ovf = m_ovf | hit;
        end
        if (in_last) begin
          predict(m_acc, m_ovf, 0, rr.d0, rr.s0);
          predict(m_acc, m_ovf, 1, rr.d1, rr.s1);
          predict(m_acc, m_ovf, 2, rr.d2, rr.s2);
          rr.due = en_cnt + LAT;
          q.push_back(rr);
        end
      end
      if (q.size() > 0 && q[0].due == en_cnt) begin
        e_v = 1'b1;
        e_d = '{q[0].d0, q[0].d1, q[0].d2};
        e_s = '{q[0].s0, q[0].s1, q[0].s2};
        void'(q.pop_front());
      end else begin
        e_v = 1'b0;
      end
    end
    #1;
    chk("u0_valid", longint'(ov0), longint'(e_v));
    chk("u0_data",  longint'($signed(od0)), e_d[0]);
    chk("u0_sat",   longint'(os0), longint'(e_s[0]));
    chk("u1_valid", longint'(ov1), longint'(e_v));
    chk("u1_data",  longint'($signed(od1)), e_d[1]);
    chk("u1_sat",   longint'(os1), longint'(e_s[1]));
    chk("u2_valid", longint'(ov2), longint'(e_v));
    chk("u2_data",  longint'($signed(od2)), e_d[2]);
    chk("u2_sat",   longint'(os2), longint'(e_s[2]));
  end

  task automatic put(input bit v, input bit f, input bit l, input longint av, input longint bv);
    @(negedge clk);
    ce       = 1'b1;
    in_valid = v;
    in_first = f;
    in_last  = l;
    a        = A_W'(av);
    b        = B_W'(bv);
  endtask

  task automatic idle(input int n);
    repeat (n) put(1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic stall(input int n);
    repeat (n) begin
      @(negedge clk);
      ce       = 1'b0;
      in_valid = 1'b0;
    end
  endtask

  task automatic dot4_head();
    put(1'b1, 1'b1, 1'b0, 1, 10);
    put(1'b1, 1'b0, 1'b0, 2, 20);
  endtask

  task automatic dot4_tail(input bit with_first);
    put(1'b1, with_first, 1'b0, 3, 30);
    put(1'b1, 1'b0, 1'b1, 4, 40);
  endtask

  initial begin
    chk("reset_valid", longint'(ov0), 0);
    chk("reset_data",  longint'(od0), 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    idle(2);

    put(1'b1, 1'b1, 1'b1, -3, 5);
    idle(7);
    chk("single_shot", longint'($signed(od0)), -15);

    dot4_head();
    dot4_tail(1'b0);
    idle(7);
    chk("dot_product", longint'($signed(od0)), 300);

    put(1'b1, 1'b1, 1'b1, 7, 7);
    idle(6);
    dot4_head();
    stall(3);
    dot4_tail(1'b0);
    idle(7);
    chk("dot_stall", longint'($signed(od0)), 300);

    put(1'b1, 1'b1, 1'b1, 1000, 1000);
    put(1'b1, 1'b1, 1'b1, -1000, 1000);
    put(1'b1, 1'b1, 1'b1, 100, 100);
    idle(7);
    chk("sat16_last", longint'($signed(od1)), 10000);

    put(1'b1, 1'b1, 1'b1, 24, 1);
    put(1'b1, 1'b1, 1'b1, -24, 1);
    put(1'b1, 1'b1, 1'b1, 23, 1);
    idle(7);
    chk("round_last", longint'($signed(od2)), 1);

    dot4_head();
    @(negedge clk);
    reset_n  = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    dot4_tail(1'b0);
    idle(7);
    chk("reset_resume", longint'($signed(od0)), 250);

    // Long run of maximal negative products drives the accumulator into its clamp.
    put(1'b1, 1'b1, 1'b0, -(longint'(1) <<< (A_W - 1)), (longint'(1) <<< B_W) - 1);
    repeat (8300) put(1'b1, 1'b0, 1'b0, -(longint'(1) <<< (A_W - 1)), (longint'(1) <<< B_W) - 1);
    put(1'b1, 1'b0, 1'b1, 1, 1);
    idle(7);
    chk("acc_ovf_sat", longint'(os0), 1);

    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      reset_n  = ($urandom_range(0, 149) != 0);
      ce       = ($urandom_range(0, 9) != 0);
      in_valid = ($urandom_range(0, 3) != 0);
      in_first = ($urandom_range(0, 4) == 0);
      in_last  = ($urandom_range(0, 4) == 0);
      a        = A_W'($urandom);
      b        = B_W'($urandom);
    end
    @(negedge clk);
    reset_n = 1'b1;
    idle(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
